// File: rtl/map_cfg_loader.sv
// Collects the MCU mapper configuration frame into a shadow buffer and commits it
// to sys_cfg in a single cycle, holding the mapper in reset across every reload.
module map_cfg_loader #(
    parameter int          CFG_BYTES = 8,
    parameter logic [7:0]  HDR       = 8'hA5,
    parameter logic [7:0]  CS_SEED   = 8'h5A,
    parameter int          RST_HOLD  = 16,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_strobe,
    input  logic [7:0]             wr_data,
    output logic [CFG_BYTES*8-1:0] sys_cfg,
    output logic                   cfg_upd,
    output logic                   map_rst,
    output logic                   busy,
    output logic                   err_cs,
    output logic                   err_tout
);

    localparam int IDX_W  = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int GAP_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CFG_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             acc;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [CFG_BYTES*8-1:0] shadow;

    logic                   hdr_hit, pay_wr, commit, cs_fail, tout, in_frame;
    logic [CFG_BYTES*8-1:0] sys_cfg_d;
    logic                   cfg_upd_d, err_cs_d, err_tout_d, busy_d, map_rst_d;

    assign in_frame = (state == S_PAYLOAD) || (state == S_CHECK);
    assign hdr_hit  = (state == S_IDLE) && wr_strobe && (wr_data == HDR);
    assign pay_wr   = (state == S_PAYLOAD) && wr_strobe;
    assign commit   = (state == S_CHECK) && wr_strobe && (wr_data == acc);
    assign cs_fail  = (state == S_CHECK) && wr_strobe && (wr_data != acc);
    // A strobe in the expiring cycle wins over the timeout.
    assign tout     = in_frame && !wr_strobe && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sys_cfg  <= '0;
            cfg_upd  <= 1'b0;
            err_cs   <= 1'b0;
            err_tout <= 1'b0;
            busy     <= 1'b0;
            map_rst  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sys_cfg  <= sys_cfg_d;
            cfg_upd  <= cfg_upd_d;
            err_cs   <= err_cs_d;
            err_tout <= err_tout_d;
            busy     <= busy_d;
            map_rst  <= map_rst_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (hdr_hit) state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (pay_wr && (idx == IDX_LAST)) state_nxt = S_CHECK;
                else if (tout)                   state_nxt = S_HOLD;
            end
            S_CHECK:   if (wr_strobe || tout) state_nxt = S_HOLD;
            S_HOLD:    if (hold_cnt == HOLD_ONE) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sys_cfg_d  = sys_cfg;
        cfg_upd_d  = commit;
        err_cs_d   = err_cs;
        err_tout_d = err_tout;
        if (hdr_hit) begin
            err_cs_d   = 1'b0;
            err_tout_d = 1'b0;
        end
        if (cs_fail) err_cs_d = 1'b1;
        if (tout)    err_tout_d = 1'b1;
        if (commit)  sys_cfg_d = shadow;
        // busy and map_rst share the same window: header through end of HOLD.
        busy_d    = (state_nxt != S_IDLE);
        map_rst_d = busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            acc      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (hdr_hit) begin
                idx <= '0;
                acc <= CS_SEED;
            end else if (pay_wr) begin
                acc <= acc ^ wr_data;
                if (idx != IDX_LAST) idx <= idx + IDX_ONE;
            end

            if (!in_frame || wr_strobe) gap_cnt <= '0;
            else                        gap_cnt <= gap_cnt + GAP_ONE;

            if ((state != S_HOLD) && (state_nxt == S_HOLD)) hold_cnt <= HOLD_LOAD;
            else if (state == S_HOLD)                       hold_cnt <= hold_cnt - HOLD_ONE;
        end
    end

    // Shadow holds data only; its contents are meaningless until the commit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CFG_BYTES; k++) begin
            if (pay_wr && (idx == IDX_W'(k))) shadow[8*k +: 8] <= wr_data;
        end
    end

endmodule

// File: tb/tb_map_cfg_loader.sv
// Self-checking bench for map_cfg_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level checksum/commit model.
module tb_map_cfg_loader;

    localparam int         CFG_BYTES = 4;
    localparam logic [7:0] HDR       = 8'hA5;
    localparam logic [7:0] CS_SEED   = 8'h5A;
    localparam int         RST_HOLD  = 4;
    localparam int         TIMEOUT   = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_strobe = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic [CFG_BYTES*8-1:0] sys_cfg;
    logic                   cfg_upd, map_rst, busy, err_cs, err_tout;

    int          errors = 0;
    int          checks = 0;
    int          upd_cnt = 0;
    logic [31:0] model_cfg = 32'h0;

    map_cfg_loader #(
        .CFG_BYTES(CFG_BYTES),
        .HDR      (HDR),
        .CS_SEED  (CS_SEED),
        .RST_HOLD (RST_HOLD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_strobe(wr_strobe),
        .wr_data  (wr_data),
        .sys_cfg  (sys_cfg),
        .cfg_upd  (cfg_upd),
        .map_rst  (map_rst),
        .busy     (busy),
        .err_cs   (err_cs),
        .err_tout (err_tout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cfg_upd) upd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        wr_strobe = 1'b1;
        wr_data   = b;
        tick();
        wr_strobe = 1'b0;
        wr_data   = 8'($urandom);
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] cs,
                              input bit rnd_gap, input bit hold_noise);
        logic [7:0]  exp_cs;
        logic        exp_ok;
        logic        exp_hi;
        logic [31:0] exp_cfg;
        int          upd0;
        exp_cs = CS_SEED;
        for (int k = 0; k < CFG_BYTES; k++) exp_cs = exp_cs ^ pl[8*k +: 8];
        exp_ok  = (cs == exp_cs);
        exp_cfg = exp_ok ? pl : model_cfg;
        upd0    = upd_cnt;

        send(HDR);
        checks++;
        if ({busy, map_rst, err_cs, err_tout} !== 4'b1100) begin
            errors++;
            $display("FAIL frame_header busy/map_rst/err_cs/err_tout got=%b want=1100",
                     {busy, map_rst, err_cs, err_tout});
        end
        for (int k = 0; k < CFG_BYTES; k++) begin
            if (rnd_gap) idle(int'($urandom_range(0, 3)));
            send(pl[8*k +: 8]);
        end
        checks++;
        if (sys_cfg !== model_cfg || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_partial sys_cfg=%h busy=%b want sys_cfg=%h busy=1",
                     sys_cfg, busy, model_cfg);
        end
        if (rnd_gap) idle(int'($urandom_range(0, 3)));
        send(cs);
        checks++;
        if (sys_cfg !== exp_cfg || {cfg_upd, err_cs, map_rst} !== {exp_ok, !exp_ok, 1'b1}) begin
            errors++;
            $display("FAIL frame_commit sys_cfg=%h upd/err_cs/map_rst=%b want sys_cfg=%h %b",
                     sys_cfg, {cfg_upd, err_cs, map_rst}, exp_cfg, {exp_ok, !exp_ok, 1'b1});
        end
        for (int i = 1; i <= RST_HOLD; i++) begin
            if (hold_noise) begin
                wr_strobe = 1'b1;
                wr_data   = (i == 1 || i == RST_HOLD) ? HDR : 8'($urandom);
            end
            tick();
            wr_strobe = 1'b0;
            exp_hi = (i < RST_HOLD);
            checks++;
            if ({map_rst, busy, cfg_upd} !== {exp_hi, exp_hi, 1'b0}) begin
                errors++;
                $display("FAIL frame_hold[%0d] map_rst/busy/cfg_upd got=%b want=%b",
                         i, {map_rst, busy, cfg_upd}, {exp_hi, exp_hi, 1'b0});
            end
        end
        checks++;
        if ((upd_cnt - upd0) !== (exp_ok ? 1 : 0) || sys_cfg !== exp_cfg || err_cs !== !exp_ok) begin
            errors++;
            $display("FAIL frame_end upd_pulses=%0d sys_cfg=%h err_cs=%b want %0d %h %b",
                     upd_cnt - upd0, sys_cfg, err_cs, exp_ok ? 1 : 0, exp_cfg, !exp_ok);
        end
        model_cfg = exp_cfg;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if ({sys_cfg, cfg_upd, map_rst, busy, err_cs, err_tout} !== '0) begin
            errors++;
            $display("FAIL reset_state sys_cfg=%h upd/rst/busy/ecs/eto=%b want all zero",
                     sys_cfg, {cfg_upd, map_rst, busy, err_cs, err_tout});
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({sys_cfg, cfg_upd, map_rst, busy, err_cs, err_tout} !== '0) begin
            errors++;
            $display("FAIL reset_release sys_cfg=%h flags=%b want all zero",
                     sys_cfg, {cfg_upd, map_rst, busy, err_cs, err_tout});
        end
        model_cfg = 32'h0;
    endtask

    task automatic test_valid_frame();
        send_frame(32'h00100142, 8'h09, 1'b0, 1'b0);
        checks++;
        if (sys_cfg !== 32'h00100142 || {err_cs, err_tout} !== 2'b00) begin
            errors++;
            $display("FAIL valid_frame sys_cfg=%h errs=%b want 00100142 00",
                     sys_cfg, {err_cs, err_tout});
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(32'h00000007, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (sys_cfg !== 32'h00100142 || err_cs !== 1'b1) begin
            errors++;
            $display("FAIL bad_checksum sys_cfg=%h err_cs=%b want 00100142 1", sys_cfg, err_cs);
        end
    endtask

    task automatic test_timeout();
        for (int s = 0; s < 2; s++) begin
            send(HDR);
            send(8'h03);
            if (s == 1) for (int k = 1; k < CFG_BYTES; k++) send(8'($urandom));
            idle(TIMEOUT - 1);
            checks++;
            if ({err_tout, busy} !== 2'b01) begin
                errors++;
                $display("FAIL timeout_early[%0d] err_tout/busy got=%b want=01", s, {err_tout, busy});
            end
            idle(1);
            checks++;
            if ({err_tout, err_cs, map_rst, busy} !== 4'b1011 || sys_cfg !== model_cfg) begin
                errors++;
                $display("FAIL timeout_hit[%0d] eto/ecs/rst/busy=%b sys_cfg=%h want 1011 %h",
                         s, {err_tout, err_cs, map_rst, busy}, sys_cfg, model_cfg);
            end
            idle(RST_HOLD - 1);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_hold[%0d] busy got=%b want=1", s, busy);
            end
            idle(1);
            checks++;
            if ({busy, map_rst, err_tout} !== 3'b001) begin
                errors++;
                $display("FAIL timeout_release[%0d] busy/map_rst/err_tout got=%b want=001",
                         s, {busy, map_rst, err_tout});
            end
        end
        send_frame($urandom, 8'h00, 1'b0, 1'b0);
        send_frame(32'h11223344, CS_SEED ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0, 1'b0);
    endtask

    task automatic test_noise_and_inframe_hdr();
        send(8'h00);
        checks++;
        if (busy !== 1'b0 || map_rst !== 1'b0) begin
            errors++;
            $display("FAIL noise_00 busy/map_rst got=%b want=00", {busy, map_rst});
        end
        send(8'h3C);
        idle(1);
        checks++;
        if (busy !== 1'b0 || sys_cfg !== model_cfg) begin
            errors++;
            $display("FAIL noise_3c busy=%b sys_cfg=%h want 0 %h", busy, sys_cfg, model_cfg);
        end
        send_frame(32'hA5A5A5A5, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (sys_cfg !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL inframe_hdr sys_cfg got=%h want=a5a5a5a5", sys_cfg);
        end
    endtask

    task automatic test_hold_strobes_and_reset();
        send_frame(32'h0BADCAFE, CS_SEED ^ 8'h0B ^ 8'hAD ^ 8'hCA ^ 8'hFE, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (busy !== 1'b0 || sys_cfg !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL hold_strobes busy=%b sys_cfg=%h want 0 0badcafe", busy, sys_cfg);
        end
        send(HDR);
        send(8'h11);
        send(8'h22);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sys_cfg, map_rst, busy, cfg_upd, err_cs, err_tout} !== '0) begin
            errors++;
            $display("FAIL async_reset sys_cfg=%h rst/busy/upd/ecs/eto=%b want all zero",
                     sys_cfg, {map_rst, busy, cfg_upd, err_cs, err_tout});
        end
        model_cfg = 32'h0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(32'h00100142, 8'h09, 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [31:0] pl;
        logic [7:0]  cs;
        for (int n = 0; n < 12; n++) begin
            pl = $urandom;
            cs = CS_SEED;
            for (int k = 0; k < CFG_BYTES; k++) cs = cs ^ pl[8*k +: 8];
            if ($urandom_range(0, 3) == 0) cs = 8'($urandom);
            if ($urandom_range(0, 1) == 1) send(8'($urandom_range(0, 8'hA4)));
            send_frame(pl, cs, 1'b1, n[0]);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        send_frame(32'hDEADBEEF, CS_SEED ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 1'b0, 1'b0);
        send_frame(32'h01020304, CS_SEED ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 1'b0, 1'b0);
        checks++;
        if (sys_cfg !== 32'h01020304) begin
            errors++;
            $display("FAIL back_to_back sys_cfg got=%h want=01020304", sys_cfg);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_timeout();
        test_noise_and_inframe_hdr();
        test_hold_strobes_and_reset();
        test_random_frames();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_cfg_loader.md
# map_cfg_loader

Receives the mapper configuration frame streamed by the MCU and builds the `sys_cfg` vector that the mapper hub decodes. The first payload byte is the mapper index. Payload bytes go into a shadow buffer and are checked against a checksum. A valid frame is committed to `sys_cfg` in one cycle. The mapper logic is held in reset around every reload, so the hub never sees a half-written configuration.

## Interface
Parameters:
- `CFG_BYTES`, default 8: number of payload bytes; `sys_cfg` width is `CFG_BYTES*8`.
- `HDR`, default 8'hA5: frame header byte.
- `CS_SEED`, default 8'h5A: initial value of the XOR checksum.
- `RST_HOLD`, default 16: number of cycles `map_rst` stays high after the frame ends; must be ≥1.
- `TIMEOUT`, default 1024: idle cycles allowed between bytes within a frame before the frame is aborted.

Ports:
- `clk`, input, 1: the single system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_strobe`, input, 1: one-cycle qualifier for `wr_data`.
- `wr_data`, input, 8: config stream byte.
- `sys_cfg`, output, `CFG_BYTES*8`: committed configuration. Payload byte k maps to bits [8k+7:8k]; byte 0 is `map_idx`.
- `cfg_upd`, output, 1: one-cycle pulse on the cycle `sys_cfg` changes.
- `map_rst`, output, 1: active-high hold-in-reset for the mapper logic.
- `busy`, output, 1: high in every state except IDLE.
- `err_cs`, output, 1: checksum mismatch on the last frame; sticky until the next header.
- `err_tout`, output, 1: the last frame timed out; sticky until the next header.

## Operation
- Reset values: all outputs are 0, including `sys_cfg` (selects mapper 0). State = IDLE, all counters = 0.
- **IDLE**
  - Strobed byte == `HDR`: clear `err_cs` and `err_tout`, set acc = `CS_SEED`, set idx = 0, set `map_rst` = 1, go to PAYLOAD.
  - Any other strobed byte is ignored.
- **PAYLOAD**
  - Each strobe writes `shadow[idx] = wr_data`, updates acc ^= `wr_data`, and increments idx.
  - The strobe that writes idx = `CFG_BYTES-1` moves the state to CHECK.
  - A byte equal to `HDR` is treated as data; no resync occurs inside a frame.
- **CHECK**
  - On the next strobe, compare `wr_data` with acc.
  - Match: `sys_cfg` = shadow (all bytes at once), pulse `cfg_upd`, go to HOLD.
  - Mismatch: set `err_cs` = 1, leave `sys_cfg` unchanged, go to HOLD.
- **HOLD**
  - Load the counter with `RST_HOLD` on entry and decrement it every cycle.
  - When the counter reaches 0: set `map_rst` = 0, go to IDLE.
  - Strobes during HOLD are ignored.
- **Timeout** (PAYLOAD and CHECK only)
  - The gap counter clears on every strobe and increments otherwise.
  - When the counter reaches `TIMEOUT`: set `err_tout` = 1, leave `sys_cfg` unchanged, go to HOLD.
- The shadow buffer is never visible on `sys_cfg` until commit; a partial frame has no effect on `sys_cfg`.
- Index width is `$clog2(CFG_BYTES)`. idx never wraps, because CHECK is entered at `CFG_BYTES-1`.
- Asserting `rst_n` low mid-frame immediately returns every output to its reset value. The frame is lost and the shadow contents are don't-care.

## Timing
- Header strobe at cycle t: `busy` = 1 and `map_rst` = 1 at t+1.
- Checksum strobe at cycle t:
  - On a valid frame, `sys_cfg` updates and `cfg_upd` = 1 at t+1; `cfg_upd` = 0 at t+2.
  - `map_rst` stays high for cycles t+1 through t+`RST_HOLD` and is 0 at t+1+`RST_HOLD`.
  - `busy` falls in the same cycle as `map_rst`.
- On a mismatch or timeout, the error flag is set at the cycle after detection. `map_rst` is released with the same `RST_HOLD` timing as a valid frame.
- Back-to-back strobes on consecutive cycles are accepted in every state. The loader imposes no minimum byte spacing.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Valid frame** (`CFG_BYTES`=4, `RST_HOLD`=4): send A5, 42, 01, 10, 00, then 09. Expect `sys_cfg` = 32'h00100142 and a single `cfg_upd` pulse. Expect `map_rst` high for exactly 4 cycles after commit, plus the payload duration. `err_cs` = `err_tout` = 0.
- **Bad checksum**: after the valid frame, send A5, 07, 00, 00, 00, then FF (expected checksum 5D). Expect `err_cs` = 1, `sys_cfg` still 00100142, no `cfg_upd`, and `map_rst` released after `RST_HOLD`.
- **Timeout** (`TIMEOUT`=32): send A5, 03, then no strobe for 32 cycles. Expect `err_tout` = 1, `sys_cfg` unchanged, and a return to IDLE after `RST_HOLD`. A following valid frame clears `err_tout` on its header and commits normally.
- **Noise and in-frame header**: stray bytes 00 and 3C in IDLE have no effect and leave `busy` = 0. A frame with payload A5, A5, A5, A5 and checksum 5A commits `sys_cfg` = 32'hA5A5A5A5.
- **Strobes in HOLD and reset mid-frame**: strobes during HOLD (including A5) are ignored. Pulling `rst_n` low after 2 payload bytes clears `sys_cfg`, `map_rst` and `busy` to 0 asynchronously. The next valid frame then commits correctly.
